loong_round_ctrl: RTL and testbench

Round sequencer for the LOONG 4x4-nibble cipher core.
- Accepts a start pulse and steps the datapath through an initial key addition, then NUM_ROUNDS rounds of AddConstants, SubCells, ShiftRows and MixColumns.
- A key addition follows every ROUNDS_PER_STEP rounds.
- Requests each round constant from the round-constant generator with a req/done handshake.
- Drives single-cycle enable strobes to the state datapath.

---
 rtl/loong_pkg.sv | 27 ++
 rtl/loong_round_ctrl.sv | 162 ++++++++++++++++
 tb/tb_loong_round_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/loong_pkg.sv
// Shared types and constants for the LOONG round sequencer.
package loong_pkg;

  localparam int LOONG_RC_DEPTH        = 33;
  localparam int LOONG_NUM_ROUNDS      = 32;
  localparam int LOONG_ROUNDS_PER_STEP = 4;

  typedef logic [5:0] rc_idx_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDKEY    = 4'd1,
    ST_RC_REQ    = 4'd2,
    ST_RC_WAIT   = 4'd3,
    ST_ADDCONST  = 4'd4,
    ST_SUBCELLS  = 4'd5,
    ST_SHIFTROWS = 4'd6,
    ST_MIXCOLS   = 4'd7,
    ST_DONE      = 4'd8
  } round_state_t;

  // The round register runs one past the last round during the final key add.
  function automatic rc_idx_t clamp_round(input rc_idx_t r, input rc_idx_t last);
    return (r > last) ? last : r;
  endfunction

endpackage

// File: rtl/loong_round_ctrl.sv
// Round sequencer for the LOONG cipher core: steps the datapath through key
// additions and rounds, fetching each round constant via a req/done handshake.
module loong_round_ctrl
  import loong_pkg::*;
#(
  parameter int NUM_ROUNDS      = LOONG_NUM_ROUNDS,
  parameter int ROUNDS_PER_STEP = LOONG_ROUNDS_PER_STEP
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [5:0] round,
  output logic       rc_req,
  output logic [5:0] rc_idx,
  input  logic       rc_done,
  output logic       en_addkey,
  output logic       en_addconst,
  output logic       en_subcells,
  output logic       en_shiftrows,
  output logic       en_mixcols
);

  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > LOONG_RC_DEPTH) || (ROUNDS_PER_STEP < 1) ||
      ((NUM_ROUNDS % ROUNDS_PER_STEP) != 0)) begin : g_param_check
    $error("loong_round_ctrl: NUM_ROUNDS must be 1..33 and a multiple of ROUNDS_PER_STEP");
  end

  localparam rc_idx_t ROUND_END = rc_idx_t'(NUM_ROUNDS);
  localparam rc_idx_t ROUND_MAX = rc_idx_t'(NUM_ROUNDS - 1);
  localparam rc_idx_t STEP      = rc_idx_t'(ROUNDS_PER_STEP);

  round_state_t state_q, state_d;
  rc_idx_t      round_q, round_d;
  rc_idx_t      round_inc_s;

  logic    busy_q, busy_d;
  logic    done_q, done_d;
  rc_idx_t round_out_q, round_out_d;
  logic    rc_req_q, rc_req_d;
  rc_idx_t rc_idx_q, rc_idx_d;
  logic    en_addkey_q, en_addkey_d;
  logic    en_addconst_q, en_addconst_d;
  logic    en_subcells_q, en_subcells_d;
  logic    en_shiftrows_q, en_shiftrows_d;
  logic    en_mixcols_q, en_mixcols_d;

  assign round_inc_s = round_q + 6'd1;

  // Next-state, round counter and output decode of the upcoming state.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      ST_IDLE: begin
        round_d = 6'd0;
        if (start) begin
          state_d = ST_ADDKEY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDKEY: begin
        if (round_q == ROUND_END) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RC_REQ;
        end
      end
      ST_RC_REQ:    state_d = ST_RC_WAIT;
      ST_RC_WAIT: begin
        if (rc_done) begin
          state_d = ST_ADDCONST;
        end else begin
          state_d = ST_RC_WAIT;
        end
      end
      ST_ADDCONST:  state_d = ST_SUBCELLS;
      ST_SUBCELLS:  state_d = ST_SHIFTROWS;
      ST_SHIFTROWS: state_d = ST_MIXCOLS;
      ST_MIXCOLS: begin
        round_d = round_inc_s;
        if ((round_inc_s % STEP) == 6'd0) begin
          state_d = ST_ADDKEY;
        end else begin
          state_d = ST_RC_REQ;
        end
      end
      ST_DONE: begin
        round_d = 6'd0;
        state_d = ST_IDLE;
      end
      default: begin
        round_d = 6'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
    rc_req_d       = (state_d == ST_RC_REQ);
    en_addkey_d    = (state_d == ST_ADDKEY);
    en_addconst_d  = (state_d == ST_ADDCONST);
    en_subcells_d  = (state_d == ST_SUBCELLS);
    en_shiftrows_d = (state_d == ST_SHIFTROWS);
    en_mixcols_d   = (state_d == ST_MIXCOLS);
    round_out_d    = clamp_round(round_d, ROUND_MAX);
    rc_idx_d       = round_d;
  end

  // State and round register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= 6'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      round_out_q    <= 6'd0;
      rc_req_q       <= 1'b0;
      rc_idx_q       <= 6'd0;
      en_addkey_q    <= 1'b0;
      en_addconst_q  <= 1'b0;
      en_subcells_q  <= 1'b0;
      en_shiftrows_q <= 1'b0;
      en_mixcols_q   <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      round_out_q    <= round_out_d;
      rc_req_q       <= rc_req_d;
      rc_idx_q       <= rc_idx_d;
      en_addkey_q    <= en_addkey_d;
      en_addconst_q  <= en_addconst_d;
      en_subcells_q  <= en_subcells_d;
      en_shiftrows_q <= en_shiftrows_d;
      en_mixcols_q   <= en_mixcols_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign round        = round_out_q;
  assign rc_req       = rc_req_q;
  assign rc_idx       = rc_idx_q;
  assign en_addkey    = en_addkey_q;
  assign en_addconst  = en_addconst_q;
  assign en_subcells  = en_subcells_q;
  assign en_shiftrows = en_shiftrows_q;
  assign en_mixcols   = en_mixcols_q;

endmodule

// File: tb/tb_loong_round_ctrl.sv
// Self-checking bench for loong_round_ctrl: default instance plus an
// 8-round / 2-rounds-per-step instance, with a randomised constant generator.
module tb_loong_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start_a, rc_done_a, start_b, rc_done_b;

  logic       busy_a, done_a, rc_req_a, ek_a, ec_a, es_a, er_a, em_a;
  logic [5:0] round_a, idx_a;
  logic       busy_b, done_b, rc_req_b, ek_b, ec_b, es_b, er_b, em_b;
  logic [5:0] round_b, idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loong_round_ctrl dut (
    .clock(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .round(round_a), .rc_req(rc_req_a), .rc_idx(idx_a), .rc_done(rc_done_a),
    .en_addkey(ek_a), .en_addconst(ec_a), .en_subcells(es_a),
    .en_shiftrows(er_a), .en_mixcols(em_a)
  );

  loong_round_ctrl #(.NUM_ROUNDS(8), .ROUNDS_PER_STEP(2)) dut8 (
    .clock(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .round(round_b), .rc_req(rc_req_b), .rc_idx(idx_b), .rc_done(rc_done_b),
    .en_addkey(ek_b), .en_addconst(ec_b), .en_subcells(es_b),
    .en_shiftrows(er_b), .en_mixcols(em_b)
  );

  // Observation word: [0]addkey [1]rc_req [2]addconst [3]subcells [4]shiftrows
  // [5]mixcols [6]done [7]busy [13:8]round [19:14]rc_idx
  logic [19:0] obs_a, obs_b;
  assign obs_a = {idx_a, round_a, busy_a, done_a, em_a, er_a, es_a, ec_a, rc_req_a, ek_a};
  assign obs_b = {idx_b, round_b, busy_b, done_b, em_b, er_b, es_b, ec_b, rc_req_b, ek_b};

  typedef struct {
    int code;
    int rnd;
    int idx;
  } ev_t;

  function automatic logic [19:0] get_obs(input bit sel);
    return sel ? obs_b : obs_a;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic set_rc(input bit sel, input logic v);
    if (sel) rc_done_b = v;
    else rc_done_a = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; rc_done_a = 1'b0; rc_done_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; rc_done_a = 1'b0; rc_done_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a !== 20'd0) begin
      errors++;
      $display("FAIL reset_a obs=%h expected 00000", obs_a);
    end
    checks++;
    if (obs_b !== 20'd0) begin
      errors++;
      $display("FAIL reset_b obs=%h expected 00000", obs_b);
    end
    rst = 1'b0;
  endtask

  // One encryption run checked against the expected event list derived from
  // the round/step rules. abort_round>=0 resets the DUT in that round's SubCells.
  task automatic run_seq(input bit sel, input int n, input int rps, input bit rand_lat,
                         input bit spur, input bit hold, input int abort_round,
                         input string tag);
    ev_t         exp_q[$];
    int          cnt[6];
    logic [19:0] o;
    int          k, cyc, pend, extra, done_cyc, code, exp_done;
    bit          fin;

    exp_q.push_back('{0, 0, -1});
    for (int r = 0; r < n; r++) begin
      exp_q.push_back('{1, r, r});
      exp_q.push_back('{2, r, r});
      exp_q.push_back('{3, r, -1});
      exp_q.push_back('{4, r, -1});
      exp_q.push_back('{5, r, -1});
      if ((r + 1) % rps == 0) exp_q.push_back('{0, (r + 1 > n - 1) ? n - 1 : r + 1, -1});
    end
    exp_q.push_back('{6, n - 1, -1});

    for (int i = 0; i < 6; i++) cnt[i] = 0;
    k = 0; cyc = 0; pend = 0; extra = 0; done_cyc = 0; fin = 1'b0;

    @(negedge clk);
    set_start(sel, 1'b1);
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!hold) set_start(sel, 1'b0);
      o = get_obs(sel);
      checks++;
      if ($countones(o[5:0]) > 1) begin
        errors++;
        $display("FAIL onehot_%s cycle %0d strobes=%b expected at most one", tag, cyc, o[5:0]);
      end
      checks++;
      if (o[7] !== 1'b1) begin
        errors++;
        $display("FAIL busy_%s cycle %0d busy=%b expected 1", tag, cyc, o[7]);
      end
      if (o[6:0] != 7'd0) begin
        code = -1;
        for (int i = 0; i < 7; i++) if (o[i] && code < 0) code = i;
        if (k >= exp_q.size()) begin
          errors++;
          $display("FAIL extra_%s cycle %0d code %0d beyond expected end", tag, cyc, code);
          fin = 1'b1;
        end else begin
          checks++;
          if (code != exp_q[k].code || o[13:8] !== 6'(exp_q[k].rnd)) begin
            errors++;
            $display("FAIL seq_%s event %0d cycle %0d got code %0d round %0d expected code %0d round %0d",
                     tag, k, cyc, code, o[13:8], exp_q[k].code, exp_q[k].rnd);
            fin = 1'b1;
          end else begin
            if (exp_q[k].idx >= 0) begin
              checks++;
              if (o[19:14] !== 6'(exp_q[k].idx)) begin
                errors++;
                $display("FAIL rc_idx_%s event %0d got %0d expected %0d", tag, k, o[19:14], exp_q[k].idx);
              end
            end
            if (k == 0) begin
              checks++;
              if (cyc != 1) begin
                errors++;
                $display("FAIL first_addkey_%s cycle %0d expected 1", tag, cyc);
              end
            end
            if (code < 6) cnt[code]++;
            if (code == 6) begin
              done_cyc = cyc;
              fin = 1'b1;
            end
            if (code == 3 && abort_round >= 0 && o[13:8] == 6'(abort_round)) begin
              rst = 1'b1;
              set_rc(sel, 1'b0);
              set_start(sel, 1'b0);
              @(negedge clk);
              o = get_obs(sel);
              checks++;
              if (o !== 20'd0) begin
                errors++;
                $display("FAIL midrun_reset_%s obs=%h expected 00000", tag, o);
              end
              rst = 1'b0;
              return;
            end
          end
          k++;
        end
      end
      set_rc(sel, 1'b0);
      if (pend > 0) begin
        pend--;
        if (pend == 0) set_rc(sel, 1'b1);
      end else if (spur && $urandom_range(2, 0) == 0) begin
        set_rc(sel, 1'b1);
      end
      if (o[1]) begin
        pend = rand_lat ? int'($urandom_range(5, 1)) : 1;
        extra += pend - 1;
      end
    end
    set_rc(sel, 1'b0);

    if (done_cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL done_seen_%s no done after %0d cycles (event %0d)", tag, cyc, k);
    end else begin
      exp_done = 6 * n + n / rps + 2 + extra;
      checks++;
      if (done_cyc != exp_done) begin
        errors++;
        $display("FAIL done_cycle_%s got %0d expected %0d", tag, done_cyc, exp_done);
      end
      checks++;
      if (cnt[0] != n / rps + 1) begin
        errors++;
        $display("FAIL addkey_count_%s got %0d expected %0d", tag, cnt[0], n / rps + 1);
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (cnt[i] != n) begin
          errors++;
          $display("FAIL strobe%0d_count_%s got %0d expected %0d", i, tag, cnt[i], n);
        end
      end
    end

    @(negedge clk);
    o = get_obs(sel);
    checks++;
    if (o[13:0] !== 14'd0) begin
      errors++;
      $display("FAIL idle_after_done_%s obs=%h expected round 0, busy 0, no strobes", tag, o);
    end
    if (hold) begin
      @(negedge clk);
      o = get_obs(sel);
      checks++;
      if (o[7:0] !== 8'h81) begin
        errors++;
        $display("FAIL restart_%s obs=%h expected busy with en_addkey only", tag, o[7:0]);
      end
      do_reset();
    end
    set_start(sel, 1'b0);
  endtask

  task automatic test_nominal();
    run_seq(1'b0, 32, 4, 1'b0, 1'b0, 1'b0, -1, "nominal");
  endtask

  task automatic test_random_latency();
    run_seq(1'b0, 32, 4, 1'b1, 1'b1, 1'b0, -1, "randlat");
  endtask

  task automatic test_midrun_reset();
    run_seq(1'b0, 32, 4, 1'b0, 1'b0, 1'b0, 13, "abort");
    run_seq(1'b0, 32, 4, 1'b0, 1'b0, 1'b0, -1, "after_rst");
  endtask

  task automatic test_start_held();
    run_seq(1'b0, 32, 4, 1'b0, 1'b0, 1'b1, -1, "held");
  endtask

  task automatic test_variant();
    run_seq(1'b1, 8, 2, 1'b0, 1'b0, 1'b0, -1, "n8");
    run_seq(1'b1, 8, 2, 1'b1, 1'b1, 1'b0, -1, "n8_randlat");
  endtask

  task automatic test_back_to_back();
    run_seq(1'b0, 32, 4, 1'b1, 1'b0, 1'b0, -1, "b2b_1");
    run_seq(1'b0, 32, 4, 1'b1, 1'b1, 1'b0, -1, "b2b_2");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random_latency();
    test_midrun_reset();
    test_start_held();
    test_variant();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
